// File: rtl/aes_pkg.sv
// Shared types and constants for the AES buffer driver: terminator word, engine
// control encodings, default buffer layout and the driver FSM state type.
package aes_pkg;

    localparam logic [31:0] SENTINEL = 32'hDEADBEEF;

    localparam int IN_BASE_DEF   = 0;
    localparam int OUT_BASE_DEF  = 257;
    localparam int MAX_WORDS_DEF = 256;
    localparam int RD_LAT_DEF    = 2;

    localparam int ADDR_W = 10;
    localparam int CNT_W  = 9;

    localparam logic [2:0] AES_CTRL_IDLE = 3'b000;
    localparam logic [2:0] AES_CTRL_ENC  = 3'b001;
    localparam logic [2:0] AES_CTRL_DEC  = 3'b010;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LOAD,
        ST_TERM,
        ST_RUN,
        ST_RELEASE,
        ST_RD_ISSUE,
        ST_RD_WAIT,
        ST_OUT,
        ST_CHECK,
        ST_DONE
    } aes_drv_state_t;

    // Buffer base plus word offset; the layout never reaches 1024 so no wrap is possible.
    function automatic logic [ADDR_W-1:0] word_addr(input int base, input logic [CNT_W-1:0] off);
        return ADDR_W'(base) + ADDR_W'(off);
    endfunction

endpackage

// File: rtl/aes_rd_lat.sv
// Read-latency tracker: a DEPTH-deep valid shift register whose tail marks the
// cycle in which mem_rdata_in carries the word addressed at issue time.
module aes_rd_lat #(
    parameter int DEPTH = 2
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic issue,
    output logic capture
);

    logic [DEPTH-1:0] vld_reg;
    logic [DEPTH-1:0] vld_next;

    assign vld_next[0] = issue;

    generate
        for (genvar gi = 1; gi < DEPTH; gi++) begin : g_stage
            assign vld_next[gi] = vld_reg[gi-1];
        end
    endgenerate

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            vld_reg <= '0;
        end else begin
            vld_reg <= vld_next;
        end
    end

    assign capture = vld_reg[DEPTH-1];

endmodule

// File: rtl/aes_buffer_driver.sv
// Host-side initiator for the AES engine shared buffer: load input words plus terminator,
// run the engine, then stream the output buffer. AES_DRV_TERM_CHECK_EN adds an output-terminator check.
module aes_buffer_driver
    import aes_pkg::*;
#(
    parameter int IN_BASE   = IN_BASE_DEF,
    parameter int OUT_BASE  = OUT_BASE_DEF,
    parameter int MAX_WORDS = MAX_WORDS_DEF,
    parameter int RD_LAT    = RD_LAT_DEF
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               s_valid_in,
    input  logic [31:0]        s_data_in,
    input  logic               s_last_in,
    input  logic               s_decrypt_in,
    output logic               s_ready_out,
    output logic               mem_own_out,
    output logic [ADDR_W-1:0]  mem_addr_out,
    output logic [3:0]         mem_we_out,
    output logic [31:0]        mem_wdata_out,
    input  logic [31:0]        mem_rdata_in,
    output logic [2:0]         aes_ctrl_out,
    input  logic               aes_complete_in,
    output logic               m_valid_out,
    output logic [31:0]        m_data_out,
    output logic               m_last_out,
    input  logic               m_ready_in,
    output logic               done_out,
    output logic               err_out
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WORDS);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    aes_drv_state_t   state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [CNT_W-1:0] idx_reg, idx_next;
    logic [CNT_W-1:0] cnt_base;
    logic             decrypt_reg, decrypt_next;
    logic             err_reg, err_next;
    logic [31:0]      data_reg, data_next;
    logic             alive_reg;
    logic             is_last;
    logic             rd_issue;
    logic             rd_capture;
`ifdef AES_DRV_TERM_CHECK_EN
    logic             chk_busy_reg, chk_busy_next;
`endif

    aes_rd_lat #(
        .DEPTH (RD_LAT)
    ) u_rd_lat (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .issue   (rd_issue),
        .capture (rd_capture)
    );

    // alive_reg keeps s_ready_out low while reset is held and for the cycle it releases.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_reg    <= ST_IDLE;
            cnt_reg      <= '0;
            idx_reg      <= '0;
            decrypt_reg  <= 1'b0;
            err_reg      <= 1'b0;
            data_reg     <= '0;
            alive_reg    <= 1'b0;
`ifdef AES_DRV_TERM_CHECK_EN
            chk_busy_reg <= 1'b0;
`endif
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            idx_reg      <= idx_next;
            decrypt_reg  <= decrypt_next;
            err_reg      <= err_next;
            data_reg     <= data_next;
            alive_reg    <= 1'b1;
`ifdef AES_DRV_TERM_CHECK_EN
            chk_busy_reg <= chk_busy_next;
`endif
        end
    end

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        idx_next      = idx_reg;
        decrypt_next  = decrypt_reg;
        err_next      = err_reg;
        data_next     = data_reg;
        cnt_base      = cnt_reg;
        is_last       = (idx_reg == cnt_reg - ONE);
        rd_issue      = 1'b0;
        s_ready_out   = 1'b0;
        mem_own_out   = 1'b1;
        mem_addr_out  = '0;
        mem_we_out    = 4'h0;
        mem_wdata_out = '0;
        aes_ctrl_out  = AES_CTRL_IDLE;
        m_valid_out   = 1'b0;
        m_last_out    = 1'b0;
        done_out      = 1'b0;
`ifdef AES_DRV_TERM_CHECK_EN
        chk_busy_next = chk_busy_reg;
`endif

        case (state_reg)
            ST_IDLE, ST_LOAD: begin
                s_ready_out = alive_reg;
                if (state_reg == ST_IDLE) begin
                    cnt_base = '0;
                end
                if (s_valid_in && alive_reg) begin
                    cnt_next = cnt_base;
                    if (state_reg == ST_IDLE) begin
                        decrypt_next = s_decrypt_in;
                        err_next     = 1'b0;
                    end
                    // Overflow words are swallowed so the host stream never stalls.
                    if (cnt_base < MAX_CNT) begin
                        mem_we_out    = 4'hf;
                        mem_addr_out  = word_addr(IN_BASE, cnt_base);
                        mem_wdata_out = s_data_in;
                        cnt_next      = cnt_base + ONE;
                    end else begin
                        err_next = 1'b1;
                    end
                    if (s_data_in == SENTINEL) begin
                        err_next = 1'b1;
                    end
                    state_next = s_last_in ? ST_TERM : ST_LOAD;
                end
            end

            ST_TERM: begin
                mem_we_out    = 4'hf;
                mem_addr_out  = word_addr(IN_BASE, cnt_reg);
                mem_wdata_out = SENTINEL;
                state_next    = ST_RUN;
            end

            ST_RUN: begin
                mem_own_out  = 1'b0;
                aes_ctrl_out = decrypt_reg ? AES_CTRL_DEC : AES_CTRL_ENC;
                if (aes_complete_in) begin
                    state_next = ST_RELEASE;
                end
            end

            ST_RELEASE: begin
                idx_next   = '0;
                state_next = ST_RD_ISSUE;
            end

            ST_RD_ISSUE: begin
                mem_addr_out = word_addr(OUT_BASE, idx_reg);
                rd_issue     = 1'b1;
                state_next   = ST_RD_WAIT;
            end

            ST_RD_WAIT: begin
                mem_addr_out = word_addr(OUT_BASE, idx_reg);
                if (rd_capture) begin
                    data_next  = mem_rdata_in;
                    state_next = ST_OUT;
                end
            end

            ST_OUT: begin
                m_valid_out = 1'b1;
                m_last_out  = is_last;
                if (m_ready_in) begin
                    idx_next = (idx_reg < MAX_CNT) ? idx_reg + ONE : idx_reg;
                    if (is_last) begin
`ifdef AES_DRV_TERM_CHECK_EN
                        state_next = ST_CHECK;
`else
                        state_next = ST_DONE;
`endif
                    end else begin
                        state_next = ST_RD_ISSUE;
                    end
                end
            end

`ifdef AES_DRV_TERM_CHECK_EN
            ST_CHECK: begin
                mem_addr_out  = word_addr(OUT_BASE, cnt_reg);
                rd_issue      = !chk_busy_reg;
                chk_busy_next = 1'b1;
                if (rd_capture) begin
                    if (mem_rdata_in != SENTINEL) begin
                        err_next = 1'b1;
                    end
                    chk_busy_next = 1'b0;
                    state_next    = ST_DONE;
                end
            end
`endif

            ST_DONE: begin
                done_out   = 1'b1;
                state_next = ST_IDLE;
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign m_data_out = data_reg;
    assign err_out    = err_reg;

endmodule

// File: tb/tb_aes_buffer_driver.sv
// Directed bench for aes_buffer_driver with a 2-cycle-latency RAM model and a simple engine model.
// Define AES_DRV_TERM_CHECK_EN for both RTL and bench to exercise the output-terminator check.
module tb_aes_buffer_driver;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        s_valid_in, s_last_in, s_decrypt_in, s_ready_out;
    logic [31:0] s_data_in;
    logic        mem_own_out;
    logic [9:0]  mem_addr_out;
    logic [3:0]  mem_we_out;
    logic [31:0] mem_wdata_out, mem_rdata_in;
    logic [2:0]  aes_ctrl_out;
    logic        aes_complete_in;
    logic        m_valid_out, m_last_out, m_ready_in;
    logic [31:0] m_data_out;
    logic        done_out, err_out;

    always #5 clk_in = ~clk_in;

    aes_buffer_driver dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .s_valid_in      (s_valid_in),
        .s_data_in       (s_data_in),
        .s_last_in       (s_last_in),
        .s_decrypt_in    (s_decrypt_in),
        .s_ready_out     (s_ready_out),
        .mem_own_out     (mem_own_out),
        .mem_addr_out    (mem_addr_out),
        .mem_we_out      (mem_we_out),
        .mem_wdata_out   (mem_wdata_out),
        .mem_rdata_in    (mem_rdata_in),
        .aes_ctrl_out    (aes_ctrl_out),
        .aes_complete_in (aes_complete_in),
        .m_valid_out     (m_valid_out),
        .m_data_out      (m_data_out),
        .m_last_out      (m_last_out),
        .m_ready_in      (m_ready_in),
        .done_out        (done_out),
        .err_out         (err_out)
    );

    // Shared RAM: driver port plus an engine-side write port, 2-cycle read latency.
    logic [31:0] ram [0:1023];
    logic [9:0]  addr_d1 = '0, addr_d2 = '0;
    logic        eng_we = 1'b0;
    logic [9:0]  eng_addr = '0;
    logic [31:0] eng_wdata = '0;

    always @(posedge clk_in) begin
        if (mem_we_out == 4'hf) ram[mem_addr_out] <= mem_wdata_out;
        if (eng_we) ram[eng_addr] <= eng_wdata;
        addr_d1 <= mem_addr_out;
        addr_d2 <= addr_d1;
    end
    assign mem_rdata_in = ram[addr_d2];

    int errors = 0;
    int checks = 0;

    logic [31:0] tx_words [0:299];
    logic [31:0] got_data [0:299];
    logic        got_last [0:299];
    int          got_n, stall_viol, stall_cnt;
    logic        done_seen, err_at_done, done_after, col_tmo;
    logic [2:0]  eng_ctrl, eng_rel;
    logic        eng_own, eng_tmo;

    function automatic logic [31:0] exp_out(input int k);
        return 32'hC0DE0000 | 32'(257 + k);
    endfunction

    task automatic send_words(input int n, input logic dec);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_in); #1;
            s_valid_in   = 1'b1;
            s_data_in    = tx_words[i];
            s_last_in    = (i == n - 1);
            s_decrypt_in = dec;
        end
        @(posedge clk_in); #1;
        s_valid_in = 1'b0;
        s_last_in  = 1'b0;
    endtask

    // Engine model: waits for a non-zero control word, fills n output words plus
    // the slot after them (terminator or zero), then pulses complete.
    task automatic engine_run(input int n, input logic wr_term);
        eng_tmo = 1'b1;
        for (int c = 0; c < 500; c++) begin
            @(negedge clk_in);
            if (aes_ctrl_out != 3'b000) begin
                eng_tmo = 1'b0;
                break;
            end
        end
        eng_ctrl = aes_ctrl_out;
        eng_own  = mem_own_out;
        if (!eng_tmo) begin
            for (int i = 0; i <= n; i++) begin
                @(posedge clk_in); #1;
                eng_we    = 1'b1;
                eng_addr  = 10'(257 + i);
                eng_wdata = (i < n) ? exp_out(i) : (wr_term ? 32'hDEADBEEF : 32'h0);
            end
            @(posedge clk_in); #1;
            eng_we = 1'b0;
            aes_complete_in = 1'b1;
            @(posedge clk_in); #1;
            aes_complete_in = 1'b0;
            @(negedge clk_in);
            eng_rel = aes_ctrl_out;
        end else begin
            eng_rel = 3'bxxx;
        end
    endtask

    task automatic collect(input int budget, input logic toggle);
        logic        stalled;
        logic [31:0] held;
        stalled = 1'b0;
        held = '0;
        got_n = 0; stall_viol = 0; stall_cnt = 0;
        done_seen = 1'b0; err_at_done = 1'bx; done_after = 1'bx; col_tmo = 1'b1;
        for (int k = 0; k < 300; k++) begin
            got_data[k] = 'x;
            got_last[k] = 1'bx;
        end
        m_ready_in = 1'b1;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk_in);
            if (stalled && (!m_valid_out || m_data_out !== held)) stall_viol++;
            stalled = 1'b0;
            if (done_out) begin
                done_seen   = 1'b1;
                err_at_done = err_out;
                col_tmo     = 1'b0;
                @(negedge clk_in);
                done_after  = done_out;
                break;
            end
            if (m_valid_out) begin
                if (m_ready_in) begin
                    if (got_n < 300) begin
                        got_data[got_n] = m_data_out;
                        got_last[got_n] = m_last_out;
                    end
                    got_n++;
                end else begin
                    stalled = 1'b1;
                    held    = m_data_out;
                    stall_cnt++;
                end
            end
            @(posedge clk_in); #1;
            if (toggle) m_ready_in = ~m_ready_in;
        end
        m_ready_in = 1'b1;
    endtask

    task automatic test_reset();
        rst_in = 1'b0;
        repeat (2) @(posedge clk_in);
        #1;
        checks++; if (mem_own_out !== 1'b1) begin errors++; $display("FAIL rst_own: got %b expected 1", mem_own_out); end
        checks++; if (aes_ctrl_out !== 3'b000) begin errors++; $display("FAIL rst_ctrl: got %b expected 000", aes_ctrl_out); end
        checks++; if (s_ready_out !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b expected 0", s_ready_out); end
        checks++; if (m_valid_out !== 1'b0) begin errors++; $display("FAIL rst_mvalid: got %b expected 0", m_valid_out); end
        checks++; if (done_out !== 1'b0) begin errors++; $display("FAIL rst_done: got %b expected 0", done_out); end
        checks++; if (err_out !== 1'b0) begin errors++; $display("FAIL rst_err: got %b expected 0", err_out); end
        checks++; if (mem_we_out !== 4'h0) begin errors++; $display("FAIL rst_we: got %h expected 0", mem_we_out); end
        @(posedge clk_in); #1;
        rst_in = 1'b1;
        @(posedge clk_in);
        @(negedge clk_in);
        checks++; if (s_ready_out !== 1'b1) begin errors++; $display("FAIL idle_ready: got %b expected 1", s_ready_out); end
        $display("txn reset: own=%b ctrl=%b", mem_own_out, aes_ctrl_out);
    endtask

    task automatic test_encrypt4();
        int bad_last;
        for (int i = 0; i < 4; i++) tx_words[i] = 32'hA0000000 + 32'(i);
        send_words(4, 1'b0);
        engine_run(4, 1'b1);
        checks++; if (eng_tmo !== 1'b0) begin errors++; $display("FAIL enc_run_tmo: got timeout expected RUN"); end
        checks++; if (eng_ctrl !== 3'b001) begin errors++; $display("FAIL enc_ctrl: got %b expected 001", eng_ctrl); end
        checks++; if (eng_own !== 1'b0) begin errors++; $display("FAIL enc_own: got %b expected 0", eng_own); end
        checks++; if (eng_rel !== 3'b000) begin errors++; $display("FAIL enc_release: got %b expected 000", eng_rel); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (ram[i] !== 32'hA0000000 + 32'(i)) begin errors++; $display("FAIL enc_ram%0d: got %h expected %h", i, ram[i], 32'hA0000000 + 32'(i)); end
        end
        checks++; if (ram[4] !== 32'hDEADBEEF) begin errors++; $display("FAIL enc_term: got %h expected deadbeef", ram[4]); end
        collect(300, 1'b0);
        checks++; if (col_tmo !== 1'b0) begin errors++; $display("FAIL enc_done_tmo: got timeout expected done"); end
        checks++; if (got_n !== 4) begin errors++; $display("FAIL enc_count: got %0d expected 4", got_n); end
        bad_last = 0;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (got_data[k] !== exp_out(k)) begin errors++; $display("FAIL enc_out%0d: got %h expected %h", k, got_data[k], exp_out(k)); end
            if (got_last[k] !== (k == 3)) bad_last++;
        end
        checks++; if (bad_last !== 0) begin errors++; $display("FAIL enc_last: got %0d wrong flags expected 0", bad_last); end
        checks++; if (err_at_done !== 1'b0) begin errors++; $display("FAIL enc_err: got %b expected 0", err_at_done); end
        checks++; if (done_after !== 1'b0) begin errors++; $display("FAIL enc_done_pulse: got %b expected 0", done_after); end
        $display("txn encrypt4: outputs=%0d err=%b", got_n, err_at_done);
    endtask

    task automatic test_overflow257();
        int bad_ram, bad_out, bad_last;
        for (int i = 0; i < 257; i++) tx_words[i] = 32'h00001000 + 32'(i);
        send_words(257, 1'b0);
        engine_run(256, 1'b1);
        bad_ram = 0;
        for (int i = 0; i < 256; i++) if (ram[i] !== 32'h00001000 + 32'(i)) bad_ram++;
        checks++; if (bad_ram !== 0) begin errors++; $display("FAIL ovf_ram: got %0d bad words expected 0", bad_ram); end
        checks++; if (ram[256] !== 32'hDEADBEEF) begin errors++; $display("FAIL ovf_term: got %h expected deadbeef", ram[256]); end
        collect(3000, 1'b0);
        checks++; if (got_n !== 256) begin errors++; $display("FAIL ovf_count: got %0d expected 256", got_n); end
        bad_out = 0; bad_last = 0;
        for (int k = 0; k < 256; k++) begin
            if (got_data[k] !== exp_out(k)) bad_out++;
            if (got_last[k] !== (k == 255)) bad_last++;
        end
        checks++; if (bad_out !== 0) begin errors++; $display("FAIL ovf_out: got %0d bad words expected 0", bad_out); end
        checks++; if (bad_last !== 0) begin errors++; $display("FAIL ovf_last: got %0d wrong flags expected 0", bad_last); end
        checks++; if (err_at_done !== 1'b1) begin errors++; $display("FAIL ovf_err: got %b expected 1", err_at_done); end
        $display("txn overflow257: outputs=%0d err=%b", got_n, err_at_done);
    endtask

    task automatic test_decrypt6_stall();
        int bad_last;
        for (int i = 0; i < 6; i++) tx_words[i] = 32'hB0000000 + 32'(i);
        send_words(6, 1'b1);
        engine_run(6, 1'b1);
        checks++; if (eng_ctrl !== 3'b010) begin errors++; $display("FAIL dec_ctrl: got %b expected 010", eng_ctrl); end
        collect(500, 1'b1);
        checks++; if (got_n !== 6) begin errors++; $display("FAIL dec_count: got %0d expected 6", got_n); end
        bad_last = 0;
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (got_data[k] !== exp_out(k)) begin errors++; $display("FAIL dec_out%0d: got %h expected %h", k, got_data[k], exp_out(k)); end
            if (got_last[k] !== (k == 5)) bad_last++;
        end
        checks++; if (bad_last !== 0) begin errors++; $display("FAIL dec_last: got %0d wrong flags expected 0", bad_last); end
        checks++; if (stall_viol !== 0) begin errors++; $display("FAIL dec_stable: got %0d unstable stalls expected 0", stall_viol); end
        checks++; if ((stall_cnt > 0) !== 1'b1) begin errors++; $display("FAIL dec_stalled: got %0d stalls expected >0", stall_cnt); end
        checks++; if (err_at_done !== 1'b0) begin errors++; $display("FAIL dec_err_clear: got %b expected 0", err_at_done); end
        $display("txn decrypt6: outputs=%0d stalls=%0d err=%b", got_n, stall_cnt, err_at_done);
    endtask

    task automatic test_sentinel_input();
        for (int i = 0; i < 4; i++) tx_words[i] = 32'hE0000000 + 32'(i);
        tx_words[1] = 32'hDEADBEEF;
        send_words(4, 1'b0);
        engine_run(4, 1'b1);
        checks++; if (ram[1] !== 32'hDEADBEEF) begin errors++; $display("FAIL sent_ram1: got %h expected deadbeef", ram[1]); end
        checks++; if (ram[2] !== 32'hE0000002) begin errors++; $display("FAIL sent_ram2: got %h expected e0000002", ram[2]); end
        collect(300, 1'b0);
        checks++; if (done_seen !== 1'b1) begin errors++; $display("FAIL sent_done: got %b expected 1", done_seen); end
        checks++; if (got_n !== 4) begin errors++; $display("FAIL sent_count: got %0d expected 4", got_n); end
        checks++; if (err_at_done !== 1'b1) begin errors++; $display("FAIL sent_err: got %b expected 1", err_at_done); end
        $display("txn sentinel_in: outputs=%0d err=%b", got_n, err_at_done);
    endtask

    task automatic test_reset_in_run();
        logic tmo;
        tx_words[0] = 32'hF0000000;
        tx_words[1] = 32'hF0000001;
        send_words(2, 1'b0);
        tmo = 1'b1;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk_in);
            if (aes_ctrl_out != 3'b000) begin
                tmo = 1'b0;
                break;
            end
        end
        checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL rr_run_tmo: got timeout expected RUN"); end
        @(posedge clk_in); #1;
        rst_in = 1'b0;
        #1;
        checks++; if (aes_ctrl_out !== 3'b000) begin errors++; $display("FAIL rr_ctrl: got %b expected 000", aes_ctrl_out); end
        checks++; if (mem_own_out !== 1'b1) begin errors++; $display("FAIL rr_own: got %b expected 1", mem_own_out); end
        @(posedge clk_in); #1;
        rst_in = 1'b1;
        @(posedge clk_in); #1;
        tx_words[0] = 32'h12345678;
        send_words(1, 1'b1);
        engine_run(1, 1'b1);
        checks++; if (eng_ctrl !== 3'b010) begin errors++; $display("FAIL rr_ctrl2: got %b expected 010", eng_ctrl); end
        checks++; if (ram[0] !== 32'h12345678) begin errors++; $display("FAIL rr_ram0: got %h expected 12345678", ram[0]); end
        checks++; if (ram[1] !== 32'hDEADBEEF) begin errors++; $display("FAIL rr_term: got %h expected deadbeef", ram[1]); end
        collect(300, 1'b0);
        checks++; if (got_n !== 1) begin errors++; $display("FAIL rr_count: got %0d expected 1", got_n); end
        checks++; if (got_data[0] !== exp_out(0)) begin errors++; $display("FAIL rr_out: got %h expected %h", got_data[0], exp_out(0)); end
        checks++; if (got_last[0] !== 1'b1) begin errors++; $display("FAIL rr_last: got %b expected 1", got_last[0]); end
        checks++; if (done_seen !== 1'b1) begin errors++; $display("FAIL rr_done: got %b expected 1", done_seen); end
        checks++; if (err_at_done !== 1'b0) begin errors++; $display("FAIL rr_err: got %b expected 0", err_at_done); end
        $display("txn reset_in_run: outputs=%0d err=%b", got_n, err_at_done);
    endtask

`ifdef AES_DRV_TERM_CHECK_EN
    task automatic test_term_check();
        tx_words[0] = 32'h00005000;
        tx_words[1] = 32'h00005001;
        send_words(2, 1'b0);
        engine_run(2, 1'b0);
        collect(300, 1'b0);
        checks++; if (err_at_done !== 1'b1) begin errors++; $display("FAIL chk_missing: got %b expected 1", err_at_done); end
        $display("txn term_check_missing: outputs=%0d err=%b", got_n, err_at_done);
        send_words(2, 1'b0);
        engine_run(2, 1'b1);
        collect(300, 1'b0);
        checks++; if (err_at_done !== 1'b0) begin errors++; $display("FAIL chk_present: got %b expected 0", err_at_done); end
        checks++; if (got_n !== 2) begin errors++; $display("FAIL chk_count: got %0d expected 2", got_n); end
        $display("txn term_check_present: outputs=%0d err=%b", got_n, err_at_done);
    endtask
`endif

    initial begin
        s_valid_in = 1'b0; s_data_in = '0; s_last_in = 1'b0; s_decrypt_in = 1'b0;
        aes_complete_in = 1'b0; m_ready_in = 1'b1;
        test_reset();
        test_encrypt4();
        test_overflow257();
        test_decrypt6_stall();
        test_sentinel_input();
        test_reset_in_run();
`ifdef AES_DRV_TERM_CHECK_EN
        test_term_check();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
